mem_access_unit: RTL

Load/store formatting stage between the pipeline's Memory stage and the word-addressed data memory. It turns ARMv4 byte, halfword and word loads and stores into word-wide data-memory accesses. Loads are extracted, rotated and extended in one cycle. Sub-word stores run as a registered two-cycle read-modify-write, and the pipeline is stalled for the first cycle.

---
 rtl/mem_access_unit_pkg.sv | 20 ++
 rtl/mem_access_unit_byte_lane_fmt.sv | 54 +++++
 rtl/mem_access_unit.sv | 94 +++++++++
 3 files changed

// File: rtl/mem_access_unit_pkg.sv
// Shared types for the load/store formatting stage: access sizes and FSM states.
package mem_access_unit_pkg;

    typedef enum logic [1:0] {
        MEM_WORD = 2'b00,
        MEM_HALF = 2'b01,
        MEM_BYTE = 2'b10
    } mem_size_t;

    typedef enum logic {
        IDLE   = 1'b0,
        RMW_WR = 1'b1
    } mau_state_t;

    // Encoding 2'b11 is reserved and behaves as a word access.
    function automatic logic is_sub_word(input logic [1:0] size);
        return (size == MEM_HALF) || (size == MEM_BYTE);
    endfunction

endpackage

// File: rtl/mem_access_unit_byte_lane_fmt.sv
// Combinational lane logic: load extract/rotate/extend and sub-word store merge.
module byte_lane_fmt
    import mem_access_unit_pkg::*;
#(
    parameter bit BIG_ENDIAN = 1'b0
) (
    input  logic [1:0]  size,
    input  logic        sign_ext,
    input  logic [1:0]  offset,
    input  logic [31:0] rd,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merge_data
);

    logic [1:0]  byte_lane;
    logic        half_lane;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] rotated;

    assign byte_lane = BIG_ENDIAN ? (2'd3 - offset) : offset;
    assign half_lane = BIG_ENDIAN ? ~offset[1] : offset[1];
    assign ld_byte   = rd[{byte_lane, 3'b000} +: 8];
    assign ld_half   = rd[{half_lane, 4'b0000} +: 16];

    // Unaligned word loads rotate in address order regardless of lane numbering.
    always_comb begin
        case (offset)
            2'd1:    rotated = {rd[7:0],  rd[31:8]};
            2'd2:    rotated = {rd[15:0], rd[31:16]};
            2'd3:    rotated = {rd[23:0], rd[31:24]};
            default: rotated = rd;
        endcase
    end

    always_comb begin
        case (mem_size_t'(size))
            MEM_BYTE: load_data = {{24{sign_ext & ld_byte[7]}}, ld_byte};
            MEM_HALF: load_data = {{16{sign_ext & ld_half[15]}}, ld_half};
            default:  load_data = rotated;
        endcase
    end

    always_comb begin
        merge_data = rd;
        case (mem_size_t'(size))
            MEM_BYTE: merge_data[{byte_lane, 3'b000} +: 8]  = wdata[7:0];
            MEM_HALF: merge_data[{half_lane, 4'b0000} +: 16] = wdata[15:0];
            default:  merge_data = wdata;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Memory-stage load/store formatter; sub-word stores use a two-cycle read-modify-write.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter bit BIG_ENDIAN = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_en,
    input  logic        mem_we,
    input  logic [1:0]  mem_size,
    input  logic        mem_signed,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        stall,
    output logic        dmem_we,
    output logic [31:0] dmem_a,
    output logic [31:0] dmem_wd,
    input  logic [31:0] dmem_rd
);

    mau_state_t  state;
    logic [31:0] merge_q;
    logic [31:0] addr_q;
    logic [31:0] load_data;
    logic [31:0] merge_data;
    logic        sub_store;

    assign sub_store = mem_en && mem_we && is_sub_word(mem_size);

    byte_lane_fmt #(.BIG_ENDIAN(BIG_ENDIAN)) u_fmt (
        .size       (mem_size),
        .sign_ext   (mem_signed),
        .offset     (addr[1:0]),
        .rd         (dmem_rd),
        .wdata      (wdata),
        .load_data  (load_data),
        .merge_data (merge_data)
    );

    // Reset masks the outputs so a pending RMW write is dropped in the reset cycle.
    always_comb begin
        rdata   = 32'h0;
        stall   = 1'b0;
        dmem_we = 1'b0;
        dmem_a  = addr;
        dmem_wd = wdata;
        case (state)
            IDLE: begin
                if (mem_en && !mem_we) begin
                    rdata = load_data;
                end else if (sub_store) begin
                    stall = 1'b1;
                end else if (mem_en && mem_we) begin
                    dmem_we = 1'b1;
                    dmem_a  = {addr[31:2], 2'b00};
                end
            end
            RMW_WR: begin
                dmem_we = 1'b1;
                dmem_a  = addr_q;
                dmem_wd = merge_q;
            end
            default: ;
        endcase
        if (reset) begin
            rdata   = 32'h0;
            stall   = 1'b0;
            dmem_we = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            merge_q <= 32'h0;
            addr_q  <= 32'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (sub_store) begin
                        merge_q <= merge_data;
                        addr_q  <= addr;
                        state   <= RMW_WR;
                    end
                end
                RMW_WR:  state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
